wash_cycle_timer: RTL and testbench

Timing sequencer that sits beside automatic_washing_machine and drives its cycle_timeout and spin_timeout inputs. It decodes the controller's valve, motor and wash outputs into a phase and loads a phase duration scaled by the selected wash program. It counts the duration down with a prescaled tick and asserts the matching timeout. It also watchdogs fill and drain and flags door-unlock-while-running faults.

---
 rtl/wash_pkg.sv | 51 +++++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/wash_cycle_timer.sv | 169 ++++++++++++++++
 tb/tb_wash_cycle_timer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// ============================================================================
// Module   : wash_pkg
// Purpose  : Shared types and duration scaling for the wash cycle timer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wash_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_DRAIN = 3'd4,
        PH_SPIN  = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        PROG_NORMAL     = 2'd0,
        PROG_QUICK      = 2'd1,
        PROG_HEAVY      = 2'd2,
        PROG_NORMAL_ALT = 2'd3
    } prog_e;

    localparam logic [1:0] c_fault_none  = 2'b00;
    localparam logic [1:0] c_fault_fill  = 2'b01;
    localparam logic [1:0] c_fault_drain = 2'b10;
    localparam logic [1:0] c_fault_door  = 2'b11;

    // Scales a base duration by program and saturates at max_val.
    function automatic logic [32:0] scale_duration(
        input logic [32:0] base,
        input prog_e       prog,
        input logic [32:0] max_val
    );
        logic [33:0] w_scaled;
        case (prog)
            PROG_QUICK: w_scaled = {1'b0, (base >> 1)};
            PROG_HEAVY: w_scaled = {base, 1'b0};
            default:    w_scaled = {1'b0, base};
        endcase
        if (w_scaled > {1'b0, max_val}) begin
            return max_val;
        end
        return w_scaled[32:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Divides clk by TICK_DIV into a one-cycle tick, with freeze/clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              c_pw   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pw-1:0] c_last = c_pw'(TICK_DIV - 1);
    localparam logic [c_pw-1:0] c_one  = c_pw'(1);

    logic [c_pw-1:0] r_cnt;
    logic            w_last;

    assign w_last = (r_cnt == c_last);
    assign o_tick = i_en & w_last;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : (r_cnt + c_one);
        end
    end

endmodule

`default_nettype wire

// File: rtl/wash_cycle_timer.sv
// ============================================================================
// Module   : wash_cycle_timer
// Purpose  : Phase timer and fill/drain/door watchdog for the washer controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wash_cycle_timer
    import wash_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int CNT_W       = 16,
    parameter int WASH_TICKS  = 600,
    parameter int RINSE_TICKS = 300,
    parameter int SPIN_TICKS  = 200,
    parameter int FILL_MAX    = 120,
    parameter int DRAIN_MAX   = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             door_lock,
    input  logic             motor_on,
    input  logic             soap_wash,
    input  logic             water_wash,
    input  logic             fill_value_on,
    input  logic             drain_value_on,
    input  logic [1:0]       program_sel,
    input  logic             clr_fault,
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [32:0]      c_cnt_max    = (33'd1 << CNT_W) - 33'd1;
    localparam logic [32:0]      c_wash_base  = 33'(WASH_TICKS);
    localparam logic [32:0]      c_rinse_base = 33'(RINSE_TICKS);
    localparam logic [32:0]      c_spin_base  = 33'(SPIN_TICKS);
    localparam logic [32:0]      c_fill_base  = 33'(FILL_MAX);
    localparam logic [32:0]      c_drain_base = 33'(DRAIN_MAX);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    phase_e           w_phase;
    phase_e           r_phase;
    prog_e            r_prog;
    logic             r_door_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load_val;
    logic             w_tick;
    logic             w_tick_en;
    logic             w_reload;
    logic             w_steady;
    logic             w_cnt_zero;
    logic             w_door_fault;
    logic             w_expired;
    logic [1:0]       w_new_code;
    logic             w_fault_d;
    logic [1:0]       w_code_d;
    logic             w_cycle_to_d;
    logic             w_spin_to_d;
    logic             r_fault;
    logic [1:0]       r_fault_code;
    logic             r_cycle_to;
    logic             r_spin_to;

    always_comb begin
        w_phase = PH_IDLE;
        if (motor_on & soap_wash) begin
            w_phase = PH_WASH;
        end else if (motor_on & water_wash) begin
            w_phase = PH_RINSE;
        end else if (motor_on) begin
            w_phase = PH_SPIN;
        end else if (fill_value_on) begin
            w_phase = PH_FILL;
        end else if (drain_value_on) begin
            w_phase = PH_DRAIN;
        end
    end

    // Watchdog limits go through the same saturation with the unscaled program.
    always_comb begin
        w_load_val = '0;
        case (w_phase)
            PH_WASH:  w_load_val = CNT_W'(scale_duration(c_wash_base,  r_prog,      c_cnt_max));
            PH_RINSE: w_load_val = CNT_W'(scale_duration(c_rinse_base, r_prog,      c_cnt_max));
            PH_SPIN:  w_load_val = CNT_W'(scale_duration(c_spin_base,  r_prog,      c_cnt_max));
            PH_FILL:  w_load_val = CNT_W'(scale_duration(c_fill_base,  PROG_NORMAL, c_cnt_max));
            PH_DRAIN: w_load_val = CNT_W'(scale_duration(c_drain_base, PROG_NORMAL, c_cnt_max));
            default:  w_load_val = '0;
        endcase
    end

    // A phase change is ignored while faulted; clr_fault always reloads.
    assign w_reload     = clr_fault | (~r_fault & (w_phase != r_phase));
    assign w_steady     = ~clr_fault & (w_phase == r_phase);
    assign w_cnt_zero   = (r_cnt == '0);
    assign w_door_fault = ~door_lock & motor_on;
    assign w_expired    = ~r_fault & w_steady & w_cnt_zero &
                          ((r_phase == PH_FILL) | (r_phase == PH_DRAIN));
    assign w_tick_en    = ~r_fault;

    always_comb begin
        w_new_code = c_fault_none;
        if (w_door_fault) begin
            w_new_code = c_fault_door;
        end else if (w_expired) begin
            w_new_code = (r_phase == PH_FILL) ? c_fault_fill : c_fault_drain;
        end
        w_fault_d = r_fault;
        w_code_d  = r_fault_code;
        if (~r_fault | clr_fault) begin
            w_fault_d = (w_new_code != c_fault_none);
            w_code_d  = w_new_code;
        end
    end

    assign w_cycle_to_d = ~w_fault_d & w_steady & w_cnt_zero &
                          ((r_phase == PH_WASH) | (r_phase == PH_RINSE));
    assign w_spin_to_d  = ~w_fault_d & w_steady & w_cnt_zero & (r_phase == PH_SPIN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .i_rst_n (reset),
        .i_en    (w_tick_en),
        .i_clr   (w_reload),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_door_d     <= 1'b0;
            r_prog       <= PROG_NORMAL;
            r_phase      <= PH_IDLE;
            r_cnt        <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= c_fault_none;
            r_cycle_to   <= 1'b0;
            r_spin_to    <= 1'b0;
        end else begin
            r_door_d <= door_lock;
            if (door_lock & ~r_door_d) begin
                r_prog <= prog_e'(program_sel);
            end
            if (w_reload) begin
                r_phase <= w_phase;
                r_cnt   <= w_load_val;
            end else if (~r_fault & w_tick & ~w_cnt_zero) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
            r_fault      <= w_fault_d;
            r_fault_code <= w_code_d;
            r_cycle_to   <= w_cycle_to_d;
            r_spin_to    <= w_spin_to_d;
        end
    end

    assign cycle_timeout = r_cycle_to;
    assign spin_timeout  = r_spin_to;
    assign fault         = r_fault;
    assign fault_code    = r_fault_code;
    assign remaining     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wash_cycle_timer.sv
// ============================================================================
// Module   : tb_wash_cycle_timer
// Purpose  : Self-checking bench: vector table, corner sequences, random vs model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wash_cycle_timer;

    localparam int TICK_DIV = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        door_lock = 1'b0, motor_on = 1'b0, soap_wash = 1'b0, water_wash = 1'b0;
    logic        fill_value_on = 1'b0, drain_value_on = 1'b0, clr_fault = 1'b0;
    logic [1:0]  program_sel = 2'd0;
    logic        cycle_timeout, spin_timeout, fault;
    logic [1:0]  fault_code;
    logic [15:0] remaining;
    logic        sat_cto, sat_sto, sat_fault;
    logic [1:0]  sat_code;
    logic [15:0] sat_remaining;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wash_cycle_timer #(
        .TICK_DIV(TICK_DIV), .CNT_W(16), .WASH_TICKS(8), .RINSE_TICKS(4),
        .SPIN_TICKS(3), .FILL_MAX(5), .DRAIN_MAX(5)
    ) dut (
        .clk(clk), .reset(reset), .door_lock(door_lock), .motor_on(motor_on),
        .soap_wash(soap_wash), .water_wash(water_wash), .fill_value_on(fill_value_on),
        .drain_value_on(drain_value_on), .program_sel(program_sel), .clr_fault(clr_fault),
        .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout), .fault(fault),
        .fault_code(fault_code), .remaining(remaining)
    );

    wash_cycle_timer #(
        .TICK_DIV(TICK_DIV), .CNT_W(16), .WASH_TICKS(40000), .RINSE_TICKS(4),
        .SPIN_TICKS(3), .FILL_MAX(5), .DRAIN_MAX(5)
    ) dut_sat (
        .clk(clk), .reset(reset), .door_lock(door_lock), .motor_on(motor_on),
        .soap_wash(soap_wash), .water_wash(water_wash), .fill_value_on(fill_value_on),
        .drain_value_on(drain_value_on), .program_sel(program_sel), .clr_fault(clr_fault),
        .cycle_timeout(sat_cto), .spin_timeout(sat_sto), .fault(sat_fault),
        .fault_code(sat_code), .remaining(sat_remaining)
    );

    // ---------------- behavioural reference model ----------------
    localparam int P_IDLE = 0, P_FILL = 1, P_WASH = 2, P_RINSE = 3, P_DRAIN = 4, P_SPIN = 5;
    int m_phase, m_left, m_sub, m_prog, m_code;
    bit m_door_prev, m_fault, m_cto, m_sto;

    function automatic int phase_now();
        if (motor_on && soap_wash)  return P_WASH;
        if (motor_on && water_wash) return P_RINSE;
        if (motor_on)               return P_SPIN;
        if (fill_value_on)          return P_FILL;
        if (drain_value_on)         return P_DRAIN;
        return P_IDLE;
    endfunction

    function automatic int phase_ticks(int ph, int prog);
        int base;
        case (ph)
            P_WASH:  base = 8;
            P_RINSE: base = 4;
            P_SPIN:  base = 3;
            P_FILL:  return 5;
            P_DRAIN: return 5;
            default: return 0;
        endcase
        if (prog == 1) return base / 2;
        if (prog == 2) return (base * 2 > 65535) ? 65535 : base * 2;
        return base;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_left = 0; m_sub = 0; m_prog = 0; m_code = 0;
        m_door_prev = 0; m_fault = 0; m_cto = 0; m_sto = 0;
    endtask

    task automatic model_step();
        int  ph, code_new;
        bit  reload, steady, expired, was_faulted;
        ph          = phase_now();
        was_faulted = m_fault;
        reload      = clr_fault || (!m_fault && ph != m_phase);
        steady      = !clr_fault && ph == m_phase;
        expired     = !m_fault && steady && m_left == 0 && (m_phase == P_FILL || m_phase == P_DRAIN);
        if (!door_lock && motor_on) code_new = 3;
        else if (expired)           code_new = (m_phase == P_FILL) ? 1 : 2;
        else                        code_new = 0;
        if (!m_fault || clr_fault) begin
            m_fault = (code_new != 0);
            m_code  = code_new;
        end
        m_cto = !m_fault && steady && m_left == 0 && (m_phase == P_WASH || m_phase == P_RINSE);
        m_sto = !m_fault && steady && m_left == 0 && m_phase == P_SPIN;
        if (reload) begin
            m_left  = phase_ticks(ph, m_prog);
            m_sub   = 0;
            m_phase = ph;
        end else if (!was_faulted) begin
            m_sub++;
            if (m_sub == TICK_DIV) begin
                m_sub = 0;
                if (m_left > 0) m_left--;
            end
        end
        if (door_lock && !m_door_prev) m_prog = int'(program_sel);
        m_door_prev = door_lock;
    endtask

    function automatic logic [31:0] model_vec();
        return 32'({m_cto, m_sto, m_fault, 2'(m_code), 16'(m_left)});
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({cycle_timeout, spin_timeout, fault, fault_code, remaining});
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        #1;
    endtask

    task automatic set_inputs(input logic [8:0] stim);
        {door_lock, motor_on, soap_wash, water_wash, fill_value_on, drain_value_on,
         program_sel, clr_fault} = stim;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_inputs(9'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // stim = {door, motor, soap, water, fill, drain, prog[1:0], clr}
    // flags = {cycle_timeout, spin_timeout, fault, fault_code[1:0]}
    typedef struct packed {
        logic [8:0]  stim;
        logic [4:0]  flags;
        logic [15:0] rem;
    } vec_t;
    vec_t tbl [22];

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n;
        int hold;

        tbl[0]  = '{9'b100000_01_0, 5'b000_00, 16'd0};
        tbl[1]  = '{9'b111000_10_0, 5'b000_00, 16'd4};
        tbl[2]  = '{9'b111000_10_0, 5'b000_00, 16'd4};
        tbl[3]  = '{9'b111000_10_0, 5'b000_00, 16'd3};
        tbl[4]  = '{9'b111000_10_0, 5'b000_00, 16'd3};
        tbl[5]  = '{9'b111000_10_0, 5'b000_00, 16'd2};
        tbl[6]  = '{9'b111000_10_0, 5'b000_00, 16'd2};
        tbl[7]  = '{9'b111000_10_0, 5'b000_00, 16'd1};
        tbl[8]  = '{9'b111000_10_0, 5'b000_00, 16'd1};
        tbl[9]  = '{9'b111000_10_0, 5'b000_00, 16'd0};
        tbl[10] = '{9'b111000_10_0, 5'b100_00, 16'd0};
        tbl[11] = '{9'b111000_10_0, 5'b100_00, 16'd0};
        tbl[12] = '{9'b110000_10_0, 5'b000_00, 16'd1};
        tbl[13] = '{9'b110000_10_0, 5'b000_00, 16'd1};
        tbl[14] = '{9'b110000_10_0, 5'b000_00, 16'd0};
        tbl[15] = '{9'b110000_10_0, 5'b010_00, 16'd0};
        tbl[16] = '{9'b010000_10_0, 5'b001_11, 16'd0};
        tbl[17] = '{9'b100010_10_0, 5'b001_11, 16'd0};
        tbl[18] = '{9'b100010_10_1, 5'b000_00, 16'd5};
        tbl[19] = '{9'b100010_10_0, 5'b000_00, 16'd5};
        tbl[20] = '{9'b100010_10_0, 5'b000_00, 16'd4};
        tbl[21] = '{9'b110100_10_0, 5'b000_00, 16'd8};

        do_reset();
        check("reset_state", dut_vec(), 32'd0);

        // Quick wash, ignored program change, quick spin, door fault, clear, heavy rinse.
        for (int i = 0; i < 22; i++) begin
            set_inputs(tbl[i].stim);
            cycle();
            check($sformatf("vec%0d", i), dut_vec(), 32'({tbl[i].flags, tbl[i].rem}));
        end

        // Async reset mid-wash, re-decode, then normal wash latency.
        do_reset();
        set_inputs(9'b111000_00_0);
        cycle();
        check("wash_load", 32'(remaining), 32'd8);
        repeat (8) cycle();
        check("wash_mid", 32'(remaining), 32'd4);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", dut_vec(), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle();
        check("reload_after_reset", 32'(remaining), 32'd8);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!cycle_timeout && n < 100);
        check("cycle_timeout_latency", 32'(n), 32'd17);
        check("wash_done_remaining", 32'(remaining), 32'd0);

        // Fill watchdog, clear, then door fault stays sticky through drain.
        do_reset();
        set_inputs(9'b100010_00_0);
        cycle();
        check("fill_load", 32'(remaining), 32'd5);
        repeat (10) cycle();
        check("fill_before_fault", dut_vec(), 32'd0);
        cycle();
        check("fill_fault", dut_vec(), 32'({5'b001_01, 16'd0}));
        repeat (2) cycle();
        check("fill_fault_held", dut_vec(), 32'({5'b001_01, 16'd0}));
        clr_fault = 1'b1;
        cycle();
        clr_fault = 1'b0;
        check("fill_clear_reload", dut_vec(), 32'({5'b000_00, 16'd5}));
        door_lock = 1'b0;
        motor_on  = 1'b1;
        cycle();
        check("door_fault", 32'({fault, fault_code}), 32'b111);
        set_inputs(9'b100001_00_0);
        repeat (15) cycle();
        check("door_code_sticky", 32'({cycle_timeout, spin_timeout, fault, fault_code}), 32'b00111);

        // Heavy program: doubled duration and saturation.
        do_reset();
        set_inputs(9'b100000_10_0);
        cycle();
        set_inputs(9'b111000_10_0);
        cycle();
        check("heavy_saturate", 32'(sat_remaining), 32'd65535);
        check("heavy_double", 32'(remaining), 32'd16);

        // Randomized traffic against the reference model.
        do_reset();
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                hold           = $urandom_range(1, 25);
                door_lock      = ($urandom_range(0, 15) != 0);
                motor_on       = 1'($urandom_range(0, 1));
                soap_wash      = 1'($urandom_range(0, 1));
                water_wash     = 1'($urandom_range(0, 1));
                fill_value_on  = 1'($urandom_range(0, 1));
                drain_value_on = 1'($urandom_range(0, 1));
                program_sel    = 2'($urandom_range(0, 3));
            end
            hold--;
            clr_fault = ($urandom_range(0, 29) == 0);
            cycle();
            check("random_vs_model", dut_vec(), model_vec());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
